// File: rtl/tenyr_run_ctl_if.sv
// Control/status bundle between a run sequencer and its host or bench.
// master drives the run request side; slave is the sequencer itself.
interface tenyr_run_ctl_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NCORES = 1
);
  logic                     start;
  logic [CNT_W-1:0]         cfg_periods;
  logic                     stop_req;
  logic [NCORES-1:0]        retire;
  logic                     core_reset;
  logic                     core_halt;
  logic                     running;
  logic                     done;
  logic [1:0]               done_reason;
  logic [CNT_W-1:0]         cycle_count;
  logic [NCORES*CNT_W-1:0]  insn_count;

  modport master (
    output start, cfg_periods, stop_req, retire,
    input  core_reset, core_halt, running, done, done_reason,
           cycle_count, insn_count
  );

  modport slave (
    input  start, cfg_periods, stop_req, retire,
    output core_reset, core_halt, running, done, done_reason,
           cycle_count, insn_count
  );
endinterface

// File: rtl/tenyr_run_ctl.sv
// Run sequencer for tenyr cores: staged reset/halt release, run-cycle and
// per-core retire counters, and a run end on cycle limit or stop request.
module tenyr_run_ctl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned NCORES       = 1,
  parameter int unsigned RESET_CYCLES = 3,
  parameter int unsigned HALT_CYCLES  = 4
) (
  input logic             clk,
  input logic             reset,
  tenyr_run_ctl_if.slave  bus
);

  localparam int unsigned PRE_MAX = (RESET_CYCLES > HALT_CYCLES) ? RESET_CYCLES : HALT_CYCLES;
  localparam int unsigned PRE_W   = $clog2(PRE_MAX + 1);

  localparam logic [PRE_W-1:0] RST_LAST  = PRE_W'(RESET_CYCLES - 1);
  localparam logic [PRE_W-1:0] HALT_LAST = PRE_W'(HALT_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRE_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  ins_q [NCORES];
  logic [CNT_W-1:0]  ins_d [NCORES];
  logic              core_reset_q, core_reset_d;
  logic              core_halt_q, core_halt_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [1:0]        reason_q, reason_d;
  logic [CNT_W-1:0]  cycle_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pre_q        <= '0;
      limit_q      <= '0;
      cycle_q      <= '0;
      ins_q        <= '{default: '0};
      core_reset_q <= 1'b1;
      core_halt_q  <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      reason_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      limit_q      <= limit_d;
      cycle_q      <= cycle_d;
      ins_q        <= ins_d;
      core_reset_q <= core_reset_d;
      core_halt_q  <= core_halt_d;
      running_q    <= running_d;
      done_q       <= done_d;
      reason_q     <= reason_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    limit_d      = limit_q;
    cycle_d      = cycle_q;
    ins_d        = ins_q;
    core_reset_d = core_reset_q;
    core_halt_d  = core_halt_q;
    running_d    = running_q;
    done_d       = done_q;
    reason_d     = reason_q;
    cycle_inc    = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A restart from DONE re-enters the full reset/halt release sequence.
        if (bus.start) begin
          state_d      = S_PRE;
          limit_d      = bus.cfg_periods;
          cycle_d      = '0;
          ins_d        = '{default: '0};
          reason_d     = 2'd0;
          pre_d        = '0;
          core_reset_d = 1'b1;
          core_halt_d  = 1'b1;
          running_d    = 1'b0;
          done_d       = 1'b0;
        end
      end

      S_PRE: begin
        pre_d = pre_q + 1'b1;
        if (pre_q == RST_LAST)  core_reset_d = 1'b0;
        if (pre_q == HALT_LAST) core_halt_d  = 1'b0;
        if (pre_q == PRE_LAST) begin
          state_d   = S_RUN;
          running_d = 1'b1;
        end
      end

      S_RUN: begin
        cycle_d = cycle_inc;
        for (int unsigned i = 0; i < NCORES; i++) begin
          if (bus.retire[i] && (ins_q[i] != '1)) ins_d[i] = ins_q[i] + 1'b1;
        end
        // The final cycle and its retires are counted; stop outranks the limit.
        if (bus.stop_req || ((limit_q != '0) && (cycle_inc == limit_q))) begin
          state_d      = S_DONE;
          reason_d     = bus.stop_req ? 2'd2 : 2'd1;
          running_d    = 1'b0;
          done_d       = 1'b1;
          core_halt_d  = 1'b1;
          core_reset_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.core_halt   = core_halt_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.done_reason = reason_q;
  assign bus.cycle_count = cycle_q;

  always_comb begin
    bus.insn_count = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      bus.insn_count[i*CNT_W +: CNT_W] = ins_q[i];
    end
  end

endmodule

// File: tb/tb_tenyr_run_ctl.sv
// Self-checking bench for tenyr_run_ctl: three parameterisations driven with
// directed and random runs, expectations derived from run-level arithmetic.
module tb_tenyr_run_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int   tests = 0;
  int   fails = 0;

  tenyr_run_ctl_if #(.CNT_W(32), .NCORES(2)) bus_a ();
  tenyr_run_ctl_if #(.CNT_W(32), .NCORES(1)) bus_b ();
  tenyr_run_ctl_if #(.CNT_W(4),  .NCORES(1)) bus_c ();

  tenyr_run_ctl #(.CNT_W(32), .NCORES(2), .RESET_CYCLES(3), .HALT_CYCLES(4)) u_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave));
  tenyr_run_ctl #(.CNT_W(32), .NCORES(1), .RESET_CYCLES(5), .HALT_CYCLES(2)) u_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave));
  tenyr_run_ctl #(.CNT_W(4), .NCORES(1), .RESET_CYCLES(3), .HALT_CYCLES(4)) u_c (
    .clk(clk), .reset(rst_c), .bus(bus_c.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: R=3, H=4, so running rises 4 edges after the start edge.
  task automatic a_start(input logic [31:0] lim);
    bus_a.cfg_periods = lim;
    bus_a.start       = 1'b1;
    tick();
    bus_a.start       = 1'b0;
    bus_a.cfg_periods = $urandom;
    chk("a_clr_cycle",  bus_a.cycle_count, 0);
    chk("a_clr_insn",   bus_a.insn_count, 0);
    chk("a_clr_reason", bus_a.done_reason, 0);
    chk("a_clr_done",   bus_a.done, 0);
    chk("a_pre_rst0",   bus_a.core_reset, 1);
    for (int k = 1; k <= 4; k++) begin
      bus_a.retire   = 2'($urandom);
      bus_a.stop_req = 1'($urandom);
      tick();
      chk("a_pre_rst",  bus_a.core_reset, (k < 3) ? 1 : 0);
      chk("a_pre_halt", bus_a.core_halt,  (k < 4) ? 1 : 0);
      chk("a_pre_run",  bus_a.running,    (k >= 4) ? 1 : 0);
    end
    chk("a_pre_insn", bus_a.insn_count, 0);
    bus_a.stop_req = 1'b0;
  endtask

  // mode 0: random retire, 1: core0 always / core1 odd cycles, 2: both always
  task automatic a_run(input logic [31:0] lim, input int stop_at, input int mode, input int ncyc);
    int fin, rsn, n;
    logic [63:0] e0, e1;
    logic [1:0] r;
    if (stop_at > 0 && (lim == 0 || stop_at <= int'(lim))) begin
      fin = stop_at; rsn = 2;
    end else if (lim != 0) begin
      fin = int'(lim); rsn = 1;
    end else begin
      fin = 0; rsn = 0;
    end
    a_start(lim);
    e0 = 0; e1 = 0;
    n  = (fin != 0) ? fin : ncyc;
    for (int j = 1; j <= n; j++) begin
      case (mode)
        0:       r = 2'($urandom);
        1:       r = {1'(j % 2 == 1), 1'b1};
        default: r = 2'b11;
      endcase
      bus_a.retire   = r;
      bus_a.stop_req = (j == stop_at);
      tick();
      e0 += 64'(r[0]);
      e1 += 64'(r[1]);
      if (fin != 0 || j == n) begin
        chk("a_run_cycle", bus_a.cycle_count, j);
        chk("a_run_done",  bus_a.done,    (j == fin) ? 1 : 0);
        chk("a_run_run",   bus_a.running, (j == fin) ? 0 : 1);
      end
    end
    bus_a.retire   = '0;
    bus_a.stop_req = 1'b0;
    chk("a_end_insn0",  bus_a.insn_count[31:0],  e0);
    chk("a_end_insn1",  bus_a.insn_count[63:32], e1);
    chk("a_end_reason", bus_a.done_reason, rsn);
    chk("a_end_halt",   bus_a.core_halt,  (fin != 0) ? 1 : 0);
    chk("a_end_rst",    bus_a.core_reset, 0);
    if (fin != 0) begin
      bus_a.retire   = 2'b11;
      bus_a.stop_req = 1'b1;
      repeat (3) tick();
      bus_a.retire   = '0;
      bus_a.stop_req = 1'b0;
      chk("a_frz_cycle",  bus_a.cycle_count, fin);
      chk("a_frz_insn0",  bus_a.insn_count[31:0],  e0);
      chk("a_frz_insn1",  bus_a.insn_count[63:32], e1);
      chk("a_frz_reason", bus_a.done_reason, rsn);
      chk("a_frz_done",   bus_a.done, 1);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    bus_a.start = 1'b0; bus_a.cfg_periods = '0; bus_a.stop_req = 1'b0; bus_a.retire = '0;
    bus_b.start = 1'b0; bus_b.cfg_periods = '0; bus_b.stop_req = 1'b0; bus_b.retire = '0;
    bus_c.start = 1'b0; bus_c.cfg_periods = '0; bus_c.stop_req = 1'b0; bus_c.retire = '0;
    repeat (2) tick();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();

    chk("rst_core_reset", bus_a.core_reset, 1);
    chk("rst_core_halt",  bus_a.core_halt, 1);
    chk("rst_running",    bus_a.running, 0);
    chk("rst_done",       bus_a.done, 0);
    chk("rst_reason",     bus_a.done_reason, 0);
    chk("rst_cycle",      bus_a.cycle_count, 0);
    chk("rst_insn",       bus_a.insn_count, 0);

    // Unlimited run: still running after 1000 cycles, then an external stop.
    repeat (6) tick();
    a_run(0, 0, 0, 1000);
    bus_a.stop_req = 1'b1;
    tick();
    bus_a.stop_req = 1'b0;
    chk("unl_stop_done",   bus_a.done, 1);
    chk("unl_stop_reason", bus_a.done_reason, 2);
    chk("unl_stop_cycle",  bus_a.cycle_count, 1001);

    a_run(10, 0, 1, 0);
    a_run(6, 6, 2, 0);
    a_run(1, 0, 0, 0);
    a_run(5, 3, 0, 0);
    for (int t = 0; t < 5; t++) begin
      a_run(32'($urandom_range(1, 12)), int'($urandom_range(0, 14)), 0, 0);
    end

    // Asynchronous reset in the middle of a run.
    a_start(0);
    bus_a.retire = 2'b11;
    repeat (3) tick();
    chk("mid_cycle3", bus_a.cycle_count, 3);
    #1 rst_a = 1'b0;
    #1;
    chk("mid_rst_core_reset", bus_a.core_reset, 1);
    chk("mid_rst_halt",       bus_a.core_halt, 1);
    chk("mid_rst_running",    bus_a.running, 0);
    chk("mid_rst_cycle",      bus_a.cycle_count, 0);
    chk("mid_rst_insn",       bus_a.insn_count, 0);
    bus_a.retire = '0;
    tick();
    rst_a = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", bus_a.core_reset, 1);
    a_run(4, 0, 0, 0);
    a_run(3, 0, 2, 0);

    // Instance B: halt released before reset, limit of 8.
    bus_b.cfg_periods = 32'd8;
    bus_b.start       = 1'b1;
    tick();
    bus_b.start       = 1'b0;
    bus_b.cfg_periods = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("b_pre_halt", bus_b.core_halt,  (k < 2) ? 1 : 0);
      chk("b_pre_rst",  bus_b.core_reset, (k < 5) ? 1 : 0);
      chk("b_pre_run",  bus_b.running,    (k >= 5) ? 1 : 0);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("b_run_done", bus_b.done, (j == 8) ? 1 : 0);
    end
    chk("b_cycle",  bus_b.cycle_count, 8);
    chk("b_reason", bus_b.done_reason, 1);
    chk("b_halt",   bus_b.core_halt, 1);

    // Instance C: 4-bit counters saturate at 15.
    bus_c.start = 1'b1;
    tick();
    bus_c.start = 1'b0;
    repeat (4) tick();
    chk("c_running", bus_c.running, 1);
    bus_c.retire = 1'b1;
    repeat (20) tick();
    chk("c_cycle_sat", bus_c.cycle_count, 15);
    chk("c_insn_sat",  bus_c.insn_count, 15);
    chk("c_still_run", bus_c.running, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tenyr_run_ctl.md
Name: tenyr_run_ctl

Overview:
Synthesizable run sequencer and performance monitor for one or more tenyr cores. It generates the core reset and halt release sequence with independent, parametrised delays. It counts run cycles and per-core retired instructions, and ends the run on a cycle limit or an external stop request, latching a completion reason. It sits between the board or bench clock/reset and the core reset/halt inputs, replacing fixed-delay bench sequencing in both simulation and FPGA builds.

Parameters:
CNT_W, 32, width of cycle and instruction counters and of cfg_periods
NCORES, 1, number of cores monitored (retire channels)
RESET_CYCLES, 3, clocks from start sample to core_reset deassertion (must be >=1)
HALT_CYCLES, 4, clocks from start sample to core_halt deassertion (must be >=1; independent of RESET_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = in reset)
start  in  1  single-cycle request to begin a run; sampled in IDLE or DONE only
cfg_periods  in  CNT_W  run-cycle limit, captured on start; 0 = unlimited
stop_req  in  1  external stop (trap/halt from core or host)
retire  in  NCORES  per-core instruction-retired strobe, one bit per core
core_reset  out  1  active-high reset to cores
core_halt  out  1  active-high halt to cores
running  out  1  high while in RUN
done  out  1  high while in DONE
done_reason  out  2  0 none, 1 limit reached, 2 stop_req
cycle_count  out  CNT_W  RUN cycles elapsed
insn_count  out  NCORES*CNT_W  packed per-core retire counts; core i at [i*CNT_W +: CNT_W]

Behaviour:
- States: IDLE, PRE, RUN, DONE. All outputs are registered.
- Reset values (async assert, synchronous release on the next edge): state IDLE, core_reset=1, core_halt=1, running=0, done=0, done_reason=0, cycle_count=0, all insn_count=0, pre-timer=0, captured limit=0.
- IDLE->PRE on start:
  - Capture cfg_periods.
  - Clear cycle_count, insn_count and done_reason.
  - Clear the pre-timer.
- PRE:
  - The pre-timer increments every clock.
  - core_reset falls exactly RESET_CYCLES clocks after the start-sampling edge.
  - core_halt falls exactly HALT_CYCLES clocks after that edge.
  - The two are independent; either may fall first.
  - PRE->RUN on the edge at which the later of the two falls (max(RESET_CYCLES,HALT_CYCLES) clocks after start); running rises on that same edge.
  - stop_req is ignored in PRE.
- RUN:
  - cycle_count increments by 1 on every edge while in RUN.
  - insn_count[i] increments on each edge where retire[i]=1. retire is ignored in all other states.
  - Counters saturate at all-ones and do not wrap.
- RUN->DONE triggers:
  - stop_req=1 sampled in RUN: reason 2.
  - Captured limit non-zero and cycle_count reaching the limit on this edge: reason 1. cycle_count then equals the limit exactly.
  - Both on the same edge: reason 2 (stop wins). The cycle and any retire on that edge are still counted.
- DONE:
  - core_halt=1, core_reset=0, running=0, done=1.
  - Counters and done_reason are frozen and held until the next start.
- start in DONE: same as from IDLE (restart). start in PRE or RUN is ignored.
- Reset mid-operation: immediate return to reset values regardless of state. Counters are not preserved.
- Limit of 1: exactly one RUN cycle, cycle_count=1.

Test Plan:
- Defaults, pulse start at cycle 10 with cfg_periods=0:
  - core_reset falls at edge 13 and core_halt at edge 14; running rises at 14.
  - With no stop, still running after 1000 cycles; cycle_count=1000 at that point.
- RESET_CYCLES=5, HALT_CYCLES=2, start then cfg_periods=8:
  - core_halt falls 2 clocks after start, core_reset 5 clocks after.
  - DONE after 8 RUN cycles with cycle_count=8, done_reason=1, core_halt=1.
- NCORES=2, retire[0] every cycle and retire[1] every other cycle for a 10-cycle limit: insn_count core0=10, core1=5. Pulses during PRE and DONE are not counted.
- stop_req and the limit coincide on the 6th RUN cycle with cfg_periods=6: done_reason=2, cycle_count=6. A retire on that edge is counted.
- CNT_W=4, unlimited run of 20 cycles, retire held high: cycle_count and insn_count saturate at 15, no wrap.
- Assert reset low during RUN at cycle_count=3:
  - Outputs immediately return to reset values (core_reset=1, counts 0).
  - After release, a new start repeats the sequence correctly.
  - A second start issued while in DONE restarts from cleared counters.
